baccarat_round_ctrl: RTL and testbench
======================================

BACCARAT_ROUND_CTRL -- requirements
Module: baccarat_round_ctrl

Interface
REQ-001 Parameter SCORE_W, default 4, width of dscore/pscore.
REQ-002 Parameter CARD_W, default 4, width of pcard3; rank encoding 1..13.
REQ-003 Parameter ROUND_W, default 8, width of round_count.
REQ-004 slow_clock  in  1  sole clock; all state on rising edge.
REQ-005 resetb  in  1  synchronous, active-high reset.
REQ-006 start  in  1  round request; sampled only in IDLE or RESULT.
REQ-007 rule_mode  in  1  0 = full punto-banco banker tableau; 1 = simplified rule (banker draws iff dscore <= 5).
REQ-008 pscore  in  SCORE_W  player hand score; valid the cycle after any load pulse.
REQ-009 dscore  in  SCORE_W  banker hand score; same timing as pscore.
REQ-010 pcard3  in  CARD_W  rank of player third card; valid the cycle after load_pcard[2].
REQ-011 load_pcard  out  3  one-hot player card load strobes, bit i = card i+1.
REQ-012 load_dcard  out  3  one-hot banker card load strobes, bit i = card i+1.
REQ-013 player_win_light, dealer_win_light  out  1 each  result; both high = tie.
REQ-014 busy  out  1  high in every state except IDLE and RESULT.
REQ-015 round_done  out  1  single-cycle pulse on entry to RESULT.
REQ-016 round_count  out  ROUND_W  completed rounds, modulo 2^ROUND_W.

Function
REQ-017 States SHALL be IDLE, DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2, EVAL, DEAL_P3, CHK_D, DEAL_D3, SETTLE, RESULT.
REQ-018 IDLE or RESULT with start=1 SHALL go to DEAL_P1 next cycle; start in any other state SHALL be ignored.
REQ-019 DEAL_P1->DEAL_D1->DEAL_P2->DEAL_D2->EVAL unconditionally, one cycle each.
REQ-020 Exactly one load strobe bit SHALL be high per DEAL_* state (the named card), zero elsewhere; outputs decoded from state (Moore).
REQ-021 EVAL: pscore>=8 or dscore>=8 (natural) -> SETTLE; else pscore<=5 -> DEAL_P3; else dscore<=5 -> DEAL_D3; else -> SETTLE.
REQ-022 DEAL_P3 -> CHK_D; CHK_D evaluates banker rule with v = (pcard3>=10 ? 0 : pcard3) -> DEAL_D3 if draw, else SETTLE.
REQ-023 rule_mode=0 banker draw: dscore 0-2 always; 3 unless v=8; 4 if v in 2..7; 5 if v in 4..7; 6 if v in 6..7; 7+ never.
REQ-024 rule_mode=1 banker draw in CHK_D iff dscore<=5; rule_mode sampled in CHK_D only.
REQ-025 Score values >9 SHALL be treated as no-draw, non-natural; comparison unsigned.
REQ-026 DEAL_D3 -> SETTLE; SETTLE -> RESULT (one cycle for scores to update).
REQ-027 On SETTLE->RESULT: lights registered from final scores: pscore>dscore player only, dscore>pscore dealer only, equal both.
REQ-028 round_count SHALL increment by 1 on SETTLE->RESULT, wrapping all-ones to 0.
REQ-029 Lights SHALL hold through RESULT and clear on the cycle leaving RESULT; 0 in all other states.
REQ-030 Latency start->round_done: 7 cycles (natural/both stand), 8 (one draw via EVAL), 9 (player draw, banker stand), 10 (both draw).

Reset
REQ-031 resetb=1 at an edge SHALL force IDLE, all strobes/lights/busy/round_done 0, round_count 0, regardless of state.
REQ-032 resetb has priority over start in the same cycle; mid-round reset issues no further strobes.

Structure
REQ-033 Package baccarat_pkg SHALL hold the state enum, RULE_FULL/RULE_SIMPLE constants and NATURAL_MIN=8, DRAW_MAX=5.
REQ-034 Banker tableau SHALL be a combinational sub-module banker_draw_rule (inputs dscore, v, rule_mode; output draw).

Verification
REQ-035 Reset, start at cycle 0, pscore=8 after DEAL_D2, dscore=3 -> strobes P1,D1,P2,D2 only, player light only, round_done at cycle 7, count=1.
REQ-036 pscore=4, pcard3=8, dscore=3, mode 0 -> P3 strobe, no D3 strobe; mode 1 same stimulus -> D3 strobe.
REQ-037 pscore=7, dscore=5 -> D3 strobe without P3; final scores 6/6 -> both lights high.
REQ-038 pcard3=12 (v=0), dscore=4, mode 0 -> no D3; dscore=2 -> D3 strobe.
REQ-039 Assert resetb in DEAL_P3 -> IDLE next cycle, all outputs 0, count 0; start during busy ignored.
REQ-040 ROUND_W=2, four back-to-back rounds from RESULT -> count 1,2,3,0.

Source files
------------

// File: rtl/baccarat_pkg.sv
// Shared types and constants for the baccarat round controller.
// Scores are compared after zero-extension to 32 bits, so the thresholds are 32-bit unsigned.
package baccarat_pkg;

   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_DEAL_P1 = 4'd1,
      S_DEAL_D1 = 4'd2,
      S_DEAL_P2 = 4'd3,
      S_DEAL_D2 = 4'd4,
      S_EVAL    = 4'd5,
      S_DEAL_P3 = 4'd6,
      S_CHK_D   = 4'd7,
      S_DEAL_D3 = 4'd8,
      S_SETTLE  = 4'd9,
      S_RESULT  = 4'd10
   } state_t;

   localparam logic        RULE_FULL   = 1'b0;
   localparam logic        RULE_SIMPLE = 1'b1;
   localparam logic [31:0] NATURAL_MIN = 32'd8;
   localparam logic [31:0] DRAW_MAX    = 32'd5;
   localparam logic [31:0] SCORE_MAX   = 32'd9;
   localparam logic [31:0] FACE_MIN    = 32'd10;

   // Card load strobes for a state: [5:3] banker cards 3..1, [2:0] player cards 3..1.
   function automatic logic [5:0] strobe_decode(input state_t s);
      logic [5:0] v;
      case (s)
         S_DEAL_P1: v = 6'b000_001;
         S_DEAL_P2: v = 6'b000_010;
         S_DEAL_P3: v = 6'b000_100;
         S_DEAL_D1: v = 6'b001_000;
         S_DEAL_D2: v = 6'b010_000;
         S_DEAL_D3: v = 6'b100_000;
         default:   v = 6'b000_000;
      endcase
      return v;
   endfunction

   function automatic logic is_busy(input state_t s);
      return (s != S_IDLE) && (s != S_RESULT);
   endfunction

endpackage

// File: rtl/banker_draw_rule.sv
// Combinational banker third-card decision after the player has drawn.
// v is the player's third-card value (face cards already mapped to 0).
module banker_draw_rule
   import baccarat_pkg::*;
#(
   parameter int SCORE_W = 4,
   parameter int CARD_W  = 4
) (
   input  logic [SCORE_W-1:0] dscore,
   input  logic [CARD_W-1:0]  v,
   input  logic               rule_mode,
   output logic               draw
);

   logic [31:0] w_d;
   logic [31:0] w_v;

   assign w_d = 32'(dscore);
   assign w_v = 32'(v);

   // Punto-banco tableau, or the simplified "draw on 0..5" rule.
   always_comb begin
      draw = 1'b0;
      if (w_d > SCORE_MAX) begin
         draw = 1'b0;
      end else if (rule_mode == RULE_SIMPLE) begin
         draw = (w_d <= DRAW_MAX);
      end else begin
         case (w_d)
            32'd0, 32'd1, 32'd2: draw = 1'b1;
            32'd3:   draw = (w_v != 32'd8);
            32'd4:   draw = (w_v >= 32'd2) && (w_v <= 32'd7);
            32'd5:   draw = (w_v >= 32'd4) && (w_v <= 32'd7);
            32'd6:   draw = (w_v >= 32'd6) && (w_v <= 32'd7);
            default: draw = 1'b0;
         endcase
      end
   end

endmodule

// File: rtl/baccarat_round_ctrl.sv
// Sequences one baccarat round: deals, third-card decisions, settlement and result lights.
// All outputs are registered from the next state so they line up with the state they describe.
module baccarat_round_ctrl
   import baccarat_pkg::*;
#(
   parameter int SCORE_W = 4,
   parameter int CARD_W  = 4,
   parameter int ROUND_W = 8
) (
   input  logic               slow_clock,
   input  logic               resetb,
   input  logic               start,
   input  logic               rule_mode,
   input  logic [SCORE_W-1:0] pscore,
   input  logic [SCORE_W-1:0] dscore,
   input  logic [CARD_W-1:0]  pcard3,
   output logic [2:0]         load_pcard,
   output logic [2:0]         load_dcard,
   output logic               player_win_light,
   output logic               dealer_win_light,
   output logic               busy,
   output logic               round_done,
   output logic [ROUND_W-1:0] round_count
);

   state_t             r_state;
   state_t             w_next;
   logic [2:0]         r_load_pcard;
   logic [2:0]         r_load_dcard;
   logic               r_player_light;
   logic               r_dealer_light;
   logic               r_busy;
   logic               r_round_done;
   logic [ROUND_W-1:0] r_round_count;

   logic [31:0]        w_p;
   logic [31:0]        w_d;
   logic               w_p_valid;
   logic               w_d_valid;
   logic               w_natural;
   logic [CARD_W-1:0]  w_v;
   logic               w_banker_draw;

   assign w_p       = 32'(pscore);
   assign w_d       = 32'(dscore);
   assign w_p_valid = (w_p <= SCORE_MAX);
   assign w_d_valid = (w_d <= SCORE_MAX);
   assign w_natural = (w_p_valid && (w_p >= NATURAL_MIN)) || (w_d_valid && (w_d >= NATURAL_MIN));
   assign w_v       = (32'(pcard3) >= FACE_MIN) ? {CARD_W{1'b0}} : pcard3;

   banker_draw_rule #(
      .SCORE_W (SCORE_W),
      .CARD_W  (CARD_W)
   ) u_banker_draw_rule (
      .dscore    (dscore),
      .v         (w_v),
      .rule_mode (rule_mode),
      .draw      (w_banker_draw)
   );

   // State register.
   always_ff @(posedge slow_clock) begin
      if (resetb) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE, S_RESULT: begin
            if (start) begin
               w_next = S_DEAL_P1;
            end else begin
               w_next = r_state;
            end
         end
         S_DEAL_P1: w_next = S_DEAL_D1;
         S_DEAL_D1: w_next = S_DEAL_P2;
         S_DEAL_P2: w_next = S_DEAL_D2;
         S_DEAL_D2: w_next = S_EVAL;
         S_EVAL: begin
            if (w_natural) begin
               w_next = S_SETTLE;
            end else if (w_p_valid && (w_p <= DRAW_MAX)) begin
               w_next = S_DEAL_P3;
            end else if (w_d_valid && (w_d <= DRAW_MAX)) begin
               w_next = S_DEAL_D3;
            end else begin
               w_next = S_SETTLE;
            end
         end
         S_DEAL_P3: w_next = S_CHK_D;
         S_CHK_D: begin
            if (w_banker_draw) begin
               w_next = S_DEAL_D3;
            end else begin
               w_next = S_SETTLE;
            end
         end
         S_DEAL_D3: w_next = S_SETTLE;
         S_SETTLE:  w_next = S_RESULT;
         default:   w_next = S_IDLE;
      endcase
   end

   // Output registers; lights latch at settlement and drop when RESULT is left.
   always_ff @(posedge slow_clock) begin
      if (resetb) begin
         r_load_pcard   <= 3'b000;
         r_load_dcard   <= 3'b000;
         r_busy         <= 1'b0;
         r_round_done   <= 1'b0;
         r_player_light <= 1'b0;
         r_dealer_light <= 1'b0;
         r_round_count  <= {ROUND_W{1'b0}};
      end else begin
         {r_load_dcard, r_load_pcard} <= strobe_decode(w_next);
         r_busy       <= is_busy(w_next);
         r_round_done <= (r_state == S_SETTLE);
         if (r_state == S_SETTLE) begin
            r_player_light <= (pscore >= dscore);
            r_dealer_light <= (dscore >= pscore);
            r_round_count  <= r_round_count + ROUND_W'(1'b1);
         end else if (w_next != S_RESULT) begin
            r_player_light <= 1'b0;
            r_dealer_light <= 1'b0;
         end else begin
            r_player_light <= r_player_light;
            r_dealer_light <= r_dealer_light;
         end
      end
   end

   assign load_pcard       = r_load_pcard;
   assign load_dcard       = r_load_dcard;
   assign player_win_light = r_player_light;
   assign dealer_win_light = r_dealer_light;
   assign busy             = r_busy;
   assign round_done       = r_round_done;
   assign round_count      = r_round_count;

endmodule

// File: tb/tb_baccarat_round_ctrl.sv
// Scoreboard bench for baccarat_round_ctrl: rounds push expectations, a monitor checks each round_done.
// A second instance with ROUND_W=2 shares the inputs to exercise counter wrap.
module tb_baccarat_round_ctrl;

   logic       slow_clock = 1'b0;
   logic       resetb     = 1'b1;
   logic       start      = 1'b0;
   logic       rule_mode  = 1'b0;
   logic [3:0] pscore     = 4'd0;
   logic [3:0] dscore     = 4'd0;
   logic [3:0] pcard3     = 4'd0;

   logic [2:0] load_pcard, load_dcard, load_pcard2, load_dcard2;
   logic       pl, dl, busy, round_done, pl2, dl2, busy2, round_done2;
   logic [7:0] round_count;
   logic [1:0] round_count2;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [5:0] strobes;
      int         busy_cycles;
      logic       pl;
      logic       dl;
      logic [7:0] cnt;
   } exp_t;

   exp_t exp_q[$];

   always #5 slow_clock = ~slow_clock;

   baccarat_round_ctrl dut (
      .slow_clock(slow_clock), .resetb(resetb), .start(start), .rule_mode(rule_mode),
      .pscore(pscore), .dscore(dscore), .pcard3(pcard3),
      .load_pcard(load_pcard), .load_dcard(load_dcard),
      .player_win_light(pl), .dealer_win_light(dl),
      .busy(busy), .round_done(round_done), .round_count(round_count)
   );

   baccarat_round_ctrl #(.ROUND_W(2)) dut_w2 (
      .slow_clock(slow_clock), .resetb(resetb), .start(start), .rule_mode(rule_mode),
      .pscore(pscore), .dscore(dscore), .pcard3(pcard3),
      .load_pcard(load_pcard2), .load_dcard(load_dcard2),
      .player_win_light(pl2), .dealer_win_light(dl2),
      .busy(busy2), .round_done(round_done2), .round_count(round_count2)
   );

   // Monitor: per-cycle strobe/light sanity plus per-round scoreboard compare.
   logic [5:0] acc_strobes = 6'd0;
   int         acc_busy    = 0;

   always @(negedge slow_clock) begin
      exp_t e;
      if (resetb) begin
         acc_strobes = 6'd0;
         acc_busy    = 0;
      end else begin
         checks++;
         if ($countones({load_dcard, load_pcard}) > 1) begin
            errors++;
            $display("FAIL onehot strobes=%b required at most one bit", {load_dcard, load_pcard});
         end
         if (busy) begin
            checks++;
            if (pl || dl) begin
               errors++;
               $display("FAIL lights_busy got %b%b required 00", pl, dl);
            end
         end
         acc_strobes = acc_strobes | {load_dcard, load_pcard};
         if (busy) acc_busy++;
         if (round_done) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_round_done count=%0d required no round", round_count);
            end else begin
               e = exp_q.pop_front();
               checks++;
               if (acc_strobes !== e.strobes) begin
                  errors++;
                  $display("FAIL strobes got %b required %b", acc_strobes, e.strobes);
               end
               checks++;
               if (acc_busy != e.busy_cycles) begin
                  errors++;
                  $display("FAIL latency busy_cycles got %0d required %0d", acc_busy, e.busy_cycles);
               end
               checks++;
               if ({pl, dl} !== {e.pl, e.dl}) begin
                  errors++;
                  $display("FAIL lights got %b%b required %b%b", pl, dl, e.pl, e.dl);
               end
               checks++;
               if (round_count !== e.cnt) begin
                  errors++;
                  $display("FAIL count got %0d required %0d", round_count, e.cnt);
               end
               checks++;
               if (round_count2 !== e.cnt[1:0] || round_done2 !== 1'b1) begin
                  errors++;
                  $display("FAIL count_w2 got %0d done %b required %0d done 1",
                           round_count2, round_done2, e.cnt[1:0]);
               end
            end
            acc_strobes = 6'd0;
            acc_busy    = 0;
         end
      end
   end

   task automatic check_quiet(input string name);
      checks++;
      if ({load_pcard, load_dcard, busy, round_done, pl, dl} !== 10'd0 ||
          round_count !== 8'd0 || round_count2 !== 2'd0) begin
         errors++;
         $display("FAIL %s got strobes=%b%b busy=%b done=%b lights=%b%b cnt=%0d/%0d required all 0",
                  name, load_dcard, load_pcard, busy, round_done, pl, dl, round_count, round_count2);
      end
   endtask

   // One round: initial scores, player third card and final scores delivered on strobes.
   task automatic run_round(input logic mode, input logic [3:0] p, input logic [3:0] d,
                            input logic [3:0] c3, input logic [3:0] pf, input logic [3:0] df,
                            input logic [5:0] es, input int ebusy, input logic epl,
                            input logic edl, input logic [7:0] ecnt, input bit mid_start);
      exp_t e;
      bit   seen;
      e.strobes = es; e.busy_cycles = ebusy; e.pl = epl; e.dl = edl; e.cnt = ecnt;
      exp_q.push_back(e);
      @(negedge slow_clock);
      rule_mode = mode; pscore = p; dscore = d; pcard3 = 4'd0; start = 1'b1;
      @(negedge slow_clock);
      start = 1'b0;
      seen  = 1'b0;
      for (int k = 0; k < 30 && !seen; k++) begin
         @(negedge slow_clock);
         start = (mid_start && k == 2);
         if (load_pcard[2]) begin
            pscore = pf;
            pcard3 = c3;
         end
         if (load_dcard[2]) dscore = df;
         if (round_done) seen = 1'b1;
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL round_timeout round_done=0 required 1");
      end
   endtask

   initial begin
      bit   seen;
      int   done_cnt;
      exp_t e;

      repeat (3) @(negedge slow_clock);
      check_quiet("reset_state");
      resetb = 1'b0;

      //        mode  p      d      c3     pf     df     strobes    busy pl    dl    cnt    mid
      run_round(1'b0, 4'd8,  4'd3,  4'd0,  4'd8,  4'd3,  6'b011011, 6, 1'b1, 1'b0, 8'd1, 1'b0);
      run_round(1'b0, 4'd4,  4'd3,  4'd8,  4'd2,  4'd3,  6'b011111, 8, 1'b0, 1'b1, 8'd2, 1'b1);
      run_round(1'b1, 4'd4,  4'd3,  4'd8,  4'd2,  4'd1,  6'b111111, 9, 1'b1, 1'b0, 8'd3, 1'b0);
      run_round(1'b0, 4'd7,  4'd5,  4'd0,  4'd7,  4'd7,  6'b111011, 7, 1'b1, 1'b1, 8'd4, 1'b0);
      run_round(1'b0, 4'd3,  4'd4,  4'd12, 4'd3,  4'd4,  6'b011111, 8, 1'b0, 1'b1, 8'd5, 1'b0);
      run_round(1'b0, 4'd3,  4'd2,  4'd12, 4'd3,  4'd8,  6'b111111, 9, 1'b0, 1'b1, 8'd6, 1'b0);
      run_round(1'b0, 4'd6,  4'd7,  4'd0,  4'd6,  4'd7,  6'b011011, 6, 1'b0, 1'b1, 8'd7, 1'b0);
      run_round(1'b0, 4'd12, 4'd3,  4'd0,  4'd12, 4'd4,  6'b111011, 7, 1'b1, 1'b0, 8'd8, 1'b0);

      // Reset while in DEAL_P3, with a simultaneous start that must lose to reset.
      @(negedge slow_clock);
      rule_mode = 1'b0; pscore = 4'd4; dscore = 4'd3; pcard3 = 4'd0; start = 1'b1;
      @(negedge slow_clock);
      start = 1'b0;
      seen  = 1'b0;
      for (int k = 0; k < 30 && !seen; k++) begin
         @(negedge slow_clock);
         if (load_pcard[2]) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL p3_timeout load_pcard[2]=0 required 1");
      end
      resetb = 1'b1;
      start  = 1'b1;
      @(negedge slow_clock);
      check_quiet("reset_mid_round");
      @(negedge slow_clock);
      resetb = 1'b0;
      start  = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge slow_clock);
         check_quiet("after_reset_quiet");
      end

      // Four back-to-back naturals with start held high.
      for (int r = 1; r <= 4; r++) begin
         e.strobes = 6'b011011; e.busy_cycles = 6; e.pl = 1'b1; e.dl = 1'b1; e.cnt = 8'(r);
         exp_q.push_back(e);
      end
      @(negedge slow_clock);
      pscore = 4'd8; dscore = 4'd8; start = 1'b1;
      done_cnt = 0;
      for (int k = 0; k < 60 && done_cnt < 4; k++) begin
         @(negedge slow_clock);
         if (round_done) done_cnt++;
         if (done_cnt == 4) start = 1'b0;
      end
      start = 1'b0;
      checks++;
      if (done_cnt != 4) begin
         errors++;
         $display("FAIL b2b_rounds got %0d required 4", done_cnt);
      end
      repeat (3) @(negedge slow_clock);
      checks++;
      if (busy !== 1'b0 || pl !== 1'b1 || dl !== 1'b1) begin
         errors++;
         $display("FAIL result_hold busy=%b lights=%b%b required 0 11", busy, pl, dl);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_left got %0d required 0", exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
